// File: rtl/mult_div_unit_pkg.sv
// Shared CPU decode constants and the multiply/divide unit state type.
package mult_div_unit_pkg;

  // R-type funct field values
  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_JR    = 6'h08;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit_divider.sv
// One restoring shift-subtract step on unsigned magnitudes.
module mdu_divider
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  // Shift the next dividend bit into the partial remainder and subtract if it fits.
  // A zero divisor always fits, so the quotient fills with ones and the
  // remainder ends up holding the dividend.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, divisor};
    fits     = (shifted >= {1'b0, divisor});
    rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers for a MIPS-style CPU.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ITER_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       fncode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(ITER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);

  mdu_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opb;      // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_q;    // negate product / quotient
  logic               neg_r;    // negate remainder
  logic               dz;       // divide by zero

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem_next;
  logic [WIDTH-1:0]   div_quo_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_neg);
    return is_neg ? neg_w(v) : v;
  endfunction

  assign busy = (state != IDLE);

  // Operand sign decode and the final sign fix-up of the finished magnitudes.
  always_comb begin
    signed_op = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);
    a_neg     = signed_op && op_a[WIDTH-1];
    b_neg     = signed_op && op_b[WIDTH-1];
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    prod_fix  = neg_q ? neg_2w(acc) : acc;
    hi_fix    = neg_r ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    if (dz)
      lo_fix = '1;
    else
      lo_fix = neg_q ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
  end

  mdu_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .rem      (acc[2*WIDTH-1:WIDTH]),
    .quo      (acc[WIDTH-1:0]),
    .divisor  (opb),
    .rem_next (div_rem_next),
    .quo_next (div_quo_next)
  );

  // Sequencer: accept ops in IDLE, iterate in MUL/DIV, write HI/LO in FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (fncode)
              FUNCT_MULT, FUNCT_MULTU: begin
                acc    <= {{WIDTH{1'b0}}, magnitude(op_a, a_neg)};
                opb    <= magnitude(op_b, b_neg);
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= 1'b0;
                is_div <= 1'b0;
                dz     <= 1'b0;
                cnt    <= '0;
                state  <= MUL;
              end
              FUNCT_DIV, FUNCT_DIVU: begin
                acc    <= {{WIDTH{1'b0}}, magnitude(op_a, a_neg)};
                opb    <= magnitude(op_b, b_neg);
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                is_div <= 1'b1;
                dz     <= (op_b == '0);
                cnt    <= '0;
                state  <= DIV;
              end
              FUNCT_MTHI: hi <= op_a;
              FUNCT_MTLO: lo <= op_a;
              default: ;
            endcase
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= FIX;
        end
        DIV: begin
          acc <= {div_rem_next, div_quo_next};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= hi_fix;
            lo <= lo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  fncode;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors;
  int checks;

  mult_div_unit #(
    .WIDTH       (32),
    .ITER_CYCLES (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .fncode (fncode),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present start for one cycle, return at the next negedge.
  task automatic start_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    fncode = fn;
    op_a   = a;
    op_b   = b;
    @(negedge clk);
    start  = 1'b0;
    fncode = 6'h00;
  endtask

  // Count remaining busy cycles, then check the done cycle and HI/LO.
  task automatic wait_result(input string tag, input int exp_busy,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int seen_done;
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    start  = 1'b0;
    fncode = 6'h00;
    op_a   = '0;
    op_b   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Signed and unsigned multiply
    start_op(FUNCT_MULT, 32'hFFFFFFFF, 32'h00000002);
    wait_result("mult", 33, 32'hFFFFFFFF, 32'hFFFFFFFE);
    @(negedge clk);
    chk("done_pulse_one_cycle", 32'(done), 32'd0);
    start_op(FUNCT_MULTU, 32'hFFFFFFFF, 32'h00000002);
    wait_result("multu", 33, 32'h00000001, 32'hFFFFFFFE);
    // Start in the done cycle is accepted
    start_op(FUNCT_MULT, 32'h00001234, 32'hFFFFFFFD);
    wait_result("mult_b2b", 33, 32'hFFFFFFFF, 32'hFFFFC964);

    // Signed divide, overflow case, divide by zero
    @(negedge clk);
    start_op(FUNCT_DIV, 32'hFFFFFFF9, 32'h00000002);
    wait_result("div_neg", 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    start_op(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_result("div_ovf", 33, 32'h00000000, 32'h80000000);
    start_op(FUNCT_DIVU, 32'h00000007, 32'h00000000);
    wait_result("divu_zero", 33, 32'h00000007, 32'hFFFFFFFF);
    start_op(FUNCT_DIV, 32'hFFFFFFF9, 32'h00000000);
    wait_result("div_zero", 33, 32'hFFFFFFF9, 32'hFFFFFFFF);
    start_op(FUNCT_DIVU, 32'hFFFFFFFF, 32'h00000010);
    wait_result("divu_big", 33, 32'h0000000F, 32'h0FFFFFFF);

    // MTHI / MTLO while idle, unknown funct ignored
    @(negedge clk);
    start_op(FUNCT_MTHI, 32'h12345678, 32'h0);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_done", 32'(done), 32'd0);
    start_op(FUNCT_MTLO, 32'h9ABCDEF0, 32'h0);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", hi, 32'h12345678);
    start_op(FUNCT_ADD, 32'h55555555, 32'h1);
    chk("other_busy", 32'(busy), 32'd0);
    chk("other_hi", hi, 32'h12345678);
    chk("other_lo", lo, 32'h9ABCDEF0);

    // Start while busy is ignored; HI/LO hold until FIX
    start_op(FUNCT_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    chk("busy_hold_hi", hi, 32'h12345678);
    start_op(FUNCT_MULT, 32'h00000003, 32'h00000005);
    wait_result("div_ignore", 28, 32'd2, 32'd14);

    // Reset mid-multiply
    @(negedge clk);
    start_op(FUNCT_MULT, 32'h00000003, 32'h00000005);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    fncode = FUNCT_MTHI;
    op_a = 32'hDEADBEEF;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("midrst_no_done", 32'(seen_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
